// File: rtl/ncc_scan_ctrl.sv
// ncc_scan_ctrl: descriptor load and window-scan sequencer for the 16x16 NCC PE array
// Build option: define NCC_DESC_REUSE_EN to add keep_desc, which lets a start reuse the loaded descriptor.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start / busy / done            search request, activity flag, one-cycle completion pulse
//   desc_valid/ready/data          descriptor word stream (64 words of 4 packed pixels, MSB byte first)
//   desc_word/load/row_sel/col_grp descriptor register strobe and PE row / column-group address to the array
//   win_valid/ready                search-window pixel stream
//   load_win/load_acc              array window-shift and accumulator load enables
//   score_in                       signed correlation score from the last array column
//   best_x/best_y/best_score       best-scoring template position and its score
//   keep_desc (optional)           skip the descriptor load when one is already resident
module ncc_scan_ctrl #(
    parameter int ARRAY_DIM    = 16,
    parameter int PIX_PER_WORD = 4,
    parameter int WIN_COLS     = 640,
    parameter int WIN_ROWS     = 32,
    parameter int SCORE_W      = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    output logic                                        busy,
    input  logic                                        desc_valid,
    output logic                                        desc_ready,
    input  logic [31:0]                                 desc_data,
    output logic [31:0]                                 desc_word,
    output logic                                        desc_load,
    output logic [$clog2(ARRAY_DIM)-1:0]                desc_row_sel,
    output logic [$clog2(ARRAY_DIM/PIX_PER_WORD)-1:0]   desc_col_grp,
    input  logic                                        win_valid,
    output logic                                        win_ready,
`ifdef NCC_DESC_REUSE_EN
    input  logic                                        keep_desc,
`endif
    output logic                                        load_win,
    output logic                                        load_acc,
    input  logic [SCORE_W-1:0]                          score_in,
    output logic [$clog2(WIN_COLS)-1:0]                 best_x,
    output logic [$clog2(WIN_ROWS)-1:0]                 best_y,
    output logic [SCORE_W-1:0]                          best_score,
    output logic                                        done
);
    localparam int NW = ARRAY_DIM * ARRAY_DIM / PIX_PER_WORD;
    localparam int WW = $clog2(NW);
    localparam int CW = $clog2(ARRAY_DIM / PIX_PER_WORD);
    localparam int XW = $clog2(WIN_COLS);
    localparam int YW = $clog2(WIN_ROWS);
    localparam logic [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, DESC_LOAD, SCAN, DRAIN, DONE} state_t;

    state_t             state_q;
    logic [WW-1:0]      word_idx_q;
    logic [XW-1:0]      col_q, pend_x_q, best_x_q;
    logic [YW-1:0]      row_q, pend_y_q, best_y_q;
    logic [SCORE_W-1:0] best_score_q;
    logic [31:0]        desc_word_q;
    logic               desc_load_q, pend_q, done_q;
    logic               win_xfer;
`ifdef NCC_DESC_REUSE_EN
    logic               desc_loaded_q;
`endif

    assign busy         = state_q != IDLE;
    assign desc_ready   = state_q == DESC_LOAD && !desc_load_q;
    assign win_ready    = state_q == SCAN;
    assign win_xfer     = win_ready && win_valid;
    assign load_win     = win_xfer;
    assign load_acc     = win_xfer;
    assign desc_load    = desc_load_q;
    assign desc_word    = desc_word_q;
    // word_idx still holds the accepted index during the strobe; it advances as the strobe ends
    assign desc_row_sel = word_idx_q[WW-1:CW];
    assign desc_col_grp = word_idx_q[CW-1:0];
    assign best_x       = best_x_q;
    assign best_y       = best_y_q;
    assign best_score   = best_score_q;
    assign done         = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            desc_word_q  <= '0;
            desc_load_q  <= 1'b0;
            pend_q       <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            best_score_q <= MIN_SCORE;
            done_q       <= 1'b0;
`ifdef NCC_DESC_REUSE_EN
            desc_loaded_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // score for the position accepted last cycle is on score_in now; strict > keeps the earliest tie
            if (pend_q && $signed(score_in) > $signed(best_score_q)) begin
                best_score_q <= score_in;
                best_x_q     <= pend_x_q;
                best_y_q     <= pend_y_q;
            end
            case (state_q)
                IDLE: if (start) begin
                    word_idx_q   <= '0;
                    col_q        <= '0;
                    row_q        <= '0;
                    best_score_q <= MIN_SCORE;
                    best_x_q     <= '0;
                    best_y_q     <= '0;
`ifdef NCC_DESC_REUSE_EN
                    state_q      <= keep_desc && desc_loaded_q ? SCAN : DESC_LOAD;
`else
                    state_q      <= DESC_LOAD;
`endif
                end
                DESC_LOAD: begin
                    if (desc_load_q) begin
                        desc_load_q <= 1'b0;
                        word_idx_q  <= word_idx_q + WW'(1);
                        if (word_idx_q == WW'(NW - 1)) begin
                            state_q <= SCAN;
`ifdef NCC_DESC_REUSE_EN
                            desc_loaded_q <= 1'b1;
`endif
                        end
                    end else if (desc_valid) begin
                        desc_word_q <= desc_data;
                        desc_load_q <= 1'b1;
                    end
                end
                SCAN: begin
                    // the template's right edge reaches the last array column once col >= ARRAY_DIM-1
                    pend_q <= win_xfer && col_q >= XW'(ARRAY_DIM - 1);
                    if (win_xfer) begin
                        pend_x_q <= col_q - XW'(ARRAY_DIM - 1);
                        pend_y_q <= row_q;
                        if (col_q == XW'(WIN_COLS - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + YW'(1);
                            if (row_q == YW'(WIN_ROWS - 1))
                                state_q <= DRAIN;
                        end else begin
                            col_q <= col_q + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    pend_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ncc_scan_ctrl.sv
// tb_ncc_scan_ctrl: scoreboard bench for ncc_scan_ctrl with a 20x2 search window
module tb_ncc_scan_ctrl;
    localparam int AD = 16;
    localparam int WC = 20;
    localparam int WR = 2;
    localparam int SW = 8;

    typedef struct packed {logic [3:0] r; logic [1:0] g; logic [31:0] d;} desc_t;
    typedef struct packed {logic [4:0] x; logic y; logic [7:0] s;} res_t;

    logic clk = 1'b0;
    logic rst, start, desc_valid, win_valid;
    logic [31:0] desc_data, desc_word;
    logic [SW-1:0] score_in, best_score;
    logic busy, desc_ready, desc_load, win_ready, load_win, load_acc, done;
    logic [3:0] desc_row_sel;
    logic [1:0] desc_col_grp;
    logic [4:0] best_x;
    logic best_y;
`ifdef NCC_DESC_REUSE_EN
    logic keep_desc = 1'b0;
`endif

    desc_t dq[$];
    res_t  rq[$];
    desc_t de;
    res_t  re;
    int n_tests = 0, n_fail = 0, n_dload = 0, n_lwin = 0, n_done = 0, n_bad = 0, cy;

    always #5 clk = ~clk;

    ncc_scan_ctrl #(.ARRAY_DIM(AD), .PIX_PER_WORD(4), .WIN_COLS(WC), .WIN_ROWS(WR), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
        .desc_word(desc_word), .desc_load(desc_load), .desc_row_sel(desc_row_sel),
        .desc_col_grp(desc_col_grp), .win_valid(win_valid), .win_ready(win_ready),
`ifdef NCC_DESC_REUSE_EN
        .keep_desc(keep_desc),
`endif
        .load_win(load_win), .load_acc(load_acc), .score_in(score_in),
        .best_x(best_x), .best_y(best_y), .best_score(best_score), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (desc_load) begin
            n_dload++;
            check("desc_sb_nonempty", dq.size() != 0, 1);
            if (dq.size() != 0) begin
                de = dq.pop_front();
                check("desc_row_sel", desc_row_sel, de.r);
                check("desc_col_grp", desc_col_grp, de.g);
                check("desc_word", desc_word, de.d);
            end
        end
        if (load_win) n_lwin++;
        if (load_win != (win_valid && win_ready) || load_acc != load_win || (desc_ready && desc_load)) n_bad++;
        if (done) begin
            n_done++;
            check("res_sb_nonempty", rq.size() != 0, 1);
            if (rq.size() != 0) begin
                re = rq.pop_front();
                check("best_x", best_x, re.x);
                check("best_y", best_y, re.y);
                check("best_score", best_score, re.s);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [7:0] score_of(input int mode, input int x, input int y);
        if (mode == 1) return 8'hFB;
        return (x == 3 && y == 1) ? 8'd100 : 8'(y * (WC - AD + 1) + x);
    endfunction

    task automatic load_desc(input int stop_at, output int cycles);
        int i = 0;
        cycles = 0;
        while (i < stop_at && cycles < 1000) begin
            desc_valid = 1'b1;
            desc_data = $urandom;
            if (desc_ready) begin
                dq.push_back({4'(i / 4), 2'(i % 4), desc_data});
                i++;
            end
            tick();
            cycles++;
        end
        desc_valid = 1'b0;
    endtask

    task automatic full_load();
        n_dload = 0;
        load_desc(64, cy);
        check("desc_pacing_cycles", cy, 127);
        tick();
        check("desc_load_pulses", n_dload, 64);
        check("scan_after_load", win_ready, 1);
    endtask

    task automatic run_scan(input int mode, input bit stall, input bit poke);
        int c = 0, r = 0, cyc = 0, px = 0, py = 0, base;
        bit pv = 1'b0;
        logic [7:0] junk;
        junk = mode == 0 ? 8'd120 : 8'd0;
        base = n_done;
        n_lwin = 0;
        n_bad = 0;
        while (r < WR && cyc < 2000) begin
            score_in = pv ? score_of(mode, px, py) : junk;
            pv = 1'b0;
            win_valid = stall ? (cyc % 2 == 0) : 1'b1;
            start = poke && cyc == 50;
            if (win_valid && win_ready) begin
                pv = c >= AD - 1;
                px = c - (AD - 1);
                py = r;
                if (c == WC - 1) begin
                    c = 0;
                    r++;
                end else c++;
            end
            tick();
            cyc++;
        end
        check("scan_completed", r, WR);
        win_valid = 1'b0;
        start = 1'b0;
        score_in = pv ? score_of(mode, px, py) : junk;
        tick();
        score_in = junk;
        cyc = 0;
        while (n_done == base && cyc < 20) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        check("done_pulses", n_done - base, 1);
        check("load_win_count", n_lwin, WC * WR);
        check("strobe_rules", n_bad, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        desc_valid = 1'b0;
        win_valid = 1'b0;
        desc_data = '0;
        score_in = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_desc_ready", desc_ready, 0);
        check("rst_win_ready", win_ready, 0);
        check("rst_desc_load", desc_load, 0);
        check("rst_load_win", load_win, 0);
        check("rst_done", done, 0);
        check("rst_desc_word", desc_word, 0);
        check("rst_best_x", best_x, 0);
        check("rst_best_y", best_y, 0);
        check("rst_best_score", best_score, 8'h80);
        rst = 1'b0;
        tick();

        rq.push_back({5'd3, 1'b1, 8'd100});
        do_start();
        check("busy_after_start", busy, 1);
        full_load();
        run_scan(0, 1'b0, 1'b0);
        repeat (4) tick();
        check("hold_best_score", best_score, 8'd100);
        check("hold_best_x", best_x, 3);

        rq.push_back({5'd0, 1'b0, 8'hFB});
        do_start();
        full_load();
        run_scan(1, 1'b0, 1'b0);

        rq.push_back({5'd3, 1'b1, 8'd100});
        do_start();
        full_load();
        run_scan(0, 1'b1, 1'b1);

        do_start();
        load_desc(30, cy);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_desc_ready", desc_ready, 0);
        check("midrst_desc_load", desc_load, 0);
        check("midrst_desc_word", desc_word, 0);
        check("midrst_best_score", best_score, 8'h80);
        dq.delete();
        tick();
        rst = 1'b0;
        tick();
        rq.push_back({5'd3, 1'b1, 8'd100});
        do_start();
        full_load();
        run_scan(0, 1'b0, 1'b0);

`ifdef NCC_DESC_REUSE_EN
        keep_desc = 1'b1;
        rq.push_back({5'd0, 1'b0, 8'hFB});
        do_start();
        check("reuse_scan_next", win_ready, 1);
        check("reuse_no_desc_ready", desc_ready, 0);
        run_scan(1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rq.push_back({5'd3, 1'b1, 8'd100});
        do_start();
        check("reuse_after_rst_loads", desc_ready, 1);
        keep_desc = 1'b0;
        full_load();
        run_scan(0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
